// File: rtl/zorro_bus_arbiter.sv
// Zorro expansion-bus arbiter: collects slot EBR_n requests, wins the CPU bus through BR/BG,
// then hands it to one slot at a time with grant timeout, per-slot lockout and grant reporting.
module zorro_bus_arbiter #(
    parameter int N_SLOTS       = 5,
    parameter int SLOT_W        = 3,
    parameter int GRANT_TIMEOUT = 16,
    parameter int PRIORITY_MODE = 0
) (
    input  logic               clk100,
    input  logic               reset_n_in,
    input  logic               cpuclk_rising,
    input  logic               access_state_idle,
    input  logic [N_SLOTS-1:0] ebr_n_in,
    input  logic               ebgack_n_in,
    input  logic               bg_n_in,
    output logic               br_n_out,
    output logic               br_n_oe,
    output logic [N_SLOTS-1:0] ebg_n_out,
    output logic [N_SLOTS-1:0] ebg_n_oe,
    output logic               own_n_out,
    output logic               own_n_oe,
    output logic [1:0]         bm_state,
    output logic [SLOT_W-1:0]  grant_slot,
    output logic               timeout_pulse
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ_CPU = 2'd1,
        ST_GRANTED = 2'd2,
        ST_OWNED   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_TICKS = 8'(GRANT_TIMEOUT);

    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        return N_SLOTS'(1) << idx;
    endfunction

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] idx);
        return (idx == SLOT_W'(N_SLOTS - 1)) ? '0 : idx + SLOT_W'(1);
    endfunction

    // Round-robin scans upward from rr with wrap; fixed mode always scans from slot 0.
    function automatic logic [SLOT_W-1:0] pick_winner(input logic [N_SLOTS-1:0] elig,
                                                      input logic [SLOT_W-1:0]  rr);
        logic [SLOT_W-1:0] win;
        logic              found;
        int                idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            idx = (PRIORITY_MODE == 0) ? (int'(rr) + i) % N_SLOTS : i;
            if (!found && ((elig & (N_SLOTS'(1) << idx)) != '0)) begin
                win   = SLOT_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    logic [N_SLOTS-1:0] ebr_meta_q, ebr_sync_q;
    logic               ack_meta_q, ack_sync_q;
    logic               bg_meta_q, bg_sync_q;

    state_t             state_q;
    logic               oe_q;
    logic               br_n_q;
    logic [N_SLOTS-1:0] ebg_n_q;
    logic               own_n_q;
    logic [SLOT_W-1:0]  grant_slot_q;
    logic [SLOT_W-1:0]  winner_q;
    logic [SLOT_W-1:0]  rr_q;
    logic [N_SLOTS-1:0] lockout_q;
    logic [7:0]         cnt_q;
    logic               timeout_q;

    logic [N_SLOTS-1:0] eligible_s;
    logic [N_SLOTS-1:0] lockout_d;
    logic               withdrawn_s;
    logic [7:0]         cnt_inc_s;

    // Two-flop synchronisers; reset to the released (high) level of each bus line.
    always_ff @(posedge clk100 or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ebr_meta_q <= '1;
            ebr_sync_q <= '1;
            ack_meta_q <= 1'b1;
            ack_sync_q <= 1'b1;
            bg_meta_q  <= 1'b1;
            bg_sync_q  <= 1'b1;
        end else begin
            ebr_meta_q <= ebr_n_in;
            ebr_sync_q <= ebr_meta_q;
            ack_meta_q <= ebgack_n_in;
            ack_sync_q <= ack_meta_q;
            bg_meta_q  <= bg_n_in;
            bg_sync_q  <= bg_meta_q;
        end
    end

    assign eligible_s  = ~ebr_sync_q & ~lockout_q;
    assign lockout_d   = lockout_q & ~ebr_sync_q;
    assign withdrawn_s = (ebr_sync_q & slot_onehot(winner_q)) != '0;
    assign cnt_inc_s   = cnt_q + 8'd1;

    // Arbitration FSM with registered bus outputs; it only moves on cpuclk strobes.
    always_ff @(posedge clk100 or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            oe_q         <= 1'b0;
            br_n_q       <= 1'b1;
            ebg_n_q      <= '1;
            own_n_q      <= 1'b1;
            grant_slot_q <= '0;
            winner_q     <= '0;
            rr_q         <= '0;
            lockout_q    <= '0;
            cnt_q        <= 8'd0;
            timeout_q    <= 1'b0;
        end else begin
            oe_q      <= 1'b1;
            timeout_q <= 1'b0;
            if (cpuclk_rising) begin
                lockout_q <= lockout_d;
                case (state_q)
                    ST_IDLE: begin
                        if (eligible_s != '0) begin
                            br_n_q   <= 1'b0;
                            winner_q <= pick_winner(eligible_s, rr_q);
                            state_q  <= ST_REQ_CPU;
                        end
                    end
                    ST_REQ_CPU: begin
                        if (withdrawn_s) begin
                            br_n_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (!bg_sync_q && access_state_idle) begin
                            ebg_n_q      <= ~slot_onehot(winner_q);
                            grant_slot_q <= winner_q;
                            cnt_q        <= 8'd0;
                            state_q      <= ST_GRANTED;
                        end
                    end
                    ST_GRANTED: begin
                        cnt_q <= cnt_inc_s;
                        if (!ack_sync_q) begin
                            own_n_q <= 1'b0;
                            state_q <= ST_OWNED;
                        end else if (withdrawn_s) begin
                            ebg_n_q      <= '1;
                            br_n_q       <= 1'b1;
                            grant_slot_q <= '0;
                            state_q      <= ST_IDLE;
                        end else if (cnt_inc_s == TIMEOUT_TICKS) begin
                            ebg_n_q      <= '1;
                            br_n_q       <= 1'b1;
                            grant_slot_q <= '0;
                            lockout_q    <= lockout_d | slot_onehot(winner_q);
                            timeout_q    <= 1'b1;
                            rr_q         <= next_slot(winner_q);
                            state_q      <= ST_IDLE;
                        end
                    end
                    ST_OWNED: begin
                        if (ack_sync_q) begin
                            ebg_n_q      <= '1;
                            br_n_q       <= 1'b1;
                            own_n_q      <= 1'b1;
                            grant_slot_q <= '0;
                            rr_q         <= next_slot(winner_q);
                            state_q      <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign br_n_out      = br_n_q;
    assign br_n_oe       = oe_q;
    assign ebg_n_out     = ebg_n_q;
    assign ebg_n_oe      = {N_SLOTS{oe_q}};
    assign own_n_out     = own_n_q;
    assign own_n_oe      = oe_q;
    assign bm_state      = state_q;
    assign grant_slot    = grant_slot_q;
    assign timeout_pulse = timeout_q;
endmodule

// File: tb/tb_zorro_bus_arbiter.sv
// Bench for zorro_bus_arbiter: a round-robin and a fixed-priority instance share stimulus and
// are compared every cycle against a phase/owner model, plus directed literal expectations.
module tb_zorro_bus_arbiter;
    localparam int N  = 5;
    localparam int SW = 3;
    localparam int GT = 16;
    localparam int VW = 2 * N + SW + 7;

    logic         clk100 = 1'b0;
    logic         reset_n_in, cpuclk_rising, access_state_idle, ebgack_n_in, bg_n_in;
    logic [N-1:0] ebr_n_in;

    logic          br_n [2], br_oe [2], own_n [2], own_oe [2], pulse [2];
    logic [N-1:0]  ebg_n [2], ebg_oe [2];
    logic [1:0]    st [2];
    logic [SW-1:0] slot [2];

    zorro_bus_arbiter #(.N_SLOTS(N), .SLOT_W(SW), .GRANT_TIMEOUT(GT), .PRIORITY_MODE(0)) dut_rr (
        .clk100(clk100), .reset_n_in(reset_n_in), .cpuclk_rising(cpuclk_rising),
        .access_state_idle(access_state_idle), .ebr_n_in(ebr_n_in), .ebgack_n_in(ebgack_n_in),
        .bg_n_in(bg_n_in), .br_n_out(br_n[0]), .br_n_oe(br_oe[0]), .ebg_n_out(ebg_n[0]),
        .ebg_n_oe(ebg_oe[0]), .own_n_out(own_n[0]), .own_n_oe(own_oe[0]), .bm_state(st[0]),
        .grant_slot(slot[0]), .timeout_pulse(pulse[0]));

    zorro_bus_arbiter #(.N_SLOTS(N), .SLOT_W(SW), .GRANT_TIMEOUT(GT), .PRIORITY_MODE(1)) dut_fx (
        .clk100(clk100), .reset_n_in(reset_n_in), .cpuclk_rising(cpuclk_rising),
        .access_state_idle(access_state_idle), .ebr_n_in(ebr_n_in), .ebgack_n_in(ebgack_n_in),
        .bg_n_in(bg_n_in), .br_n_out(br_n[1]), .br_n_oe(br_oe[1]), .ebg_n_out(ebg_n[1]),
        .ebg_n_oe(ebg_oe[1]), .own_n_out(own_n[1]), .own_n_oe(own_oe[1]), .bm_state(st[1]),
        .grant_slot(slot[1]), .timeout_pulse(pulse[1]));

    always #5 clk100 = ~clk100;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int own_cnt  = 0;
    int g_strobes = 0;
    int pulse_cnt = 0;
    bit auto_ack = 1'b0;
    int seq [$];
    int grants0 [$];
    int grants1 [$];
    logic [1:0] prev_st [2] = '{2'd0, 2'd0};

    // Model: phase 0..3 = idle / bus requested / slot granted / slot owns; owner = latched winner.
    int           m_ph [2], m_own [2], m_tk [2], m_rr [2];
    logic [N-1:0] m_lk [2];
    bit           m_pulse [2];
    bit           m_oe;
    logic [N-1:0] ebr_hist [2];
    logic         ack_hist [2], bg_hist [2];

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, expected %0d", nm, act, exp);
    endtask

    function automatic bit rq(logic [N-1:0] v, int k);
        return (v & (N'(1) << k)) != '0;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ph[m] = 0; m_own[m] = 0; m_tk[m] = 0; m_rr[m] = 0; m_pulse[m] = 1'b0;
            m_lk[m] = '0;
        end
        m_oe = 1'b0;
        for (int j = 0; j < 2; j++) begin
            ebr_hist[j] = '1; ack_hist[j] = 1'b1; bg_hist[j] = 1'b1;
        end
    endfunction

    function automatic void model_fsm(int m, logic [N-1:0] req_n, logic ack_n, logic bg_n);
        int pick;
        m_pulse[m] = 1'b0;
        if (!cpuclk_rising) return;
        m_lk[m] = m_lk[m] & ~req_n;
        case (m_ph[m])
            0: begin
                pick = -1;
                for (int i = 0; i < N; i++) begin
                    int s;
                    s = (m == 0) ? (m_rr[m] + i) % N : i;
                    if (pick < 0 && !rq(req_n, s) && !rq(m_lk[m], s)) pick = s;
                end
                if (pick >= 0) begin m_own[m] = pick; m_ph[m] = 1; end
            end
            1: begin
                if (rq(req_n, m_own[m])) m_ph[m] = 0;
                else if (!bg_n && access_state_idle) begin m_ph[m] = 2; m_tk[m] = 0; end
            end
            2: begin
                m_tk[m]++;
                if (!ack_n) m_ph[m] = 3;
                else if (rq(req_n, m_own[m])) m_ph[m] = 0;
                else if (m_tk[m] == GT) begin
                    m_lk[m] = m_lk[m] | (N'(1) << m_own[m]);
                    m_pulse[m] = 1'b1;
                    m_rr[m] = (m_own[m] + 1) % N;
                    m_ph[m] = 0;
                end
            end
            default: begin
                if (ack_n) begin m_rr[m] = (m_own[m] + 1) % N; m_ph[m] = 0; end
            end
        endcase
    endfunction

    function automatic void model_step();
        logic [N-1:0] e;
        logic a, g;
        e = ebr_hist[1]; a = ack_hist[1]; g = bg_hist[1];
        ebr_hist[1] = ebr_hist[0]; ack_hist[1] = ack_hist[0]; bg_hist[1] = bg_hist[0];
        ebr_hist[0] = ebr_n_in;    ack_hist[0] = ebgack_n_in; bg_hist[0] = bg_n_in;
        m_oe = 1'b1;
        for (int m = 0; m < 2; m++) model_fsm(m, e, a, g);
    endfunction

    function automatic logic [VW-1:0] exp_vec(int m);
        logic [N-1:0]  ebg;
        logic [SW-1:0] gs;
        ebg = (m_ph[m] >= 2) ? ~(N'(1) << m_own[m]) : '1;
        gs  = (m_ph[m] >= 2) ? SW'(m_own[m]) : SW'(0);
        return {m_oe, {N{m_oe}}, m_oe, (m_ph[m] == 0), ebg, (m_ph[m] != 3), 2'(m_ph[m]), gs,
                m_pulse[m]};
    endfunction

    task automatic compare(int m);
        logic [VW-1:0] a, e;
        a = {br_oe[m], ebg_oe[m], own_oe[m], br_n[m], ebg_n[m], own_n[m], st[m], slot[m], pulse[m]};
        e = exp_vec(m);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL model_cmp inst%0d t=%0t: actual %h, expected %h", m, $time, a, e);
    endtask

    task automatic cyc();
        if (cpuclk_rising && st[0] == 2'd2) g_strobes++;
        @(posedge clk100);
        if (reset_n_in) model_step();
        else model_reset();
        #1;
        for (int m = 0; m < 2; m++) compare(m);
        pulse_cnt += int'(pulse[0]);
        if (st[0] != prev_st[0]) seq.push_back(int'(st[0]));
        if (st[0] == 2'd2 && prev_st[0] != 2'd2) grants0.push_back(int'(slot[0]));
        if (st[1] == 2'd2 && prev_st[1] != 2'd2) grants1.push_back(int'(slot[1]));
        prev_st[0] = st[0];
        prev_st[1] = st[1];
        @(negedge clk100);
    endtask

    task automatic tick();
        cpuclk_rising = (cyc_n % 4 == 3);
        if (auto_ack) ebgack_n_in = !((st[0] == 2'd2) || (st[0] == 2'd3 && own_cnt < 8));
        cyc();
        cyc_n++;
        own_cnt = (st[0] == 2'd3) ? own_cnt + 1 : 0;
    endtask

    task automatic strobes(int n);
        int c = 0;
        while (c < n) begin
            if (cyc_n % 4 == 3) c++;
            tick();
        end
    endtask

    task automatic run_until(int m, logic [1:0] s, string nm);
        int b = 0;
        while (st[m] != s && b < 400) begin tick(); b++; end
        chk(nm, int'(st[m]), int'(s));
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        reset_n_in = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr [4];
        exp_rr = '{0, 4, 0, 4};
        reset_n_in = 1'b0; cpuclk_rising = 1'b0; access_state_idle = 1'b1;
        ebgack_n_in = 1'b1; bg_n_in = 1'b1; ebr_n_in = '1;
        model_reset();
        @(negedge clk100);
        tick();
        tick();
        chk("reset_br_oe", int'(br_oe[0]), 0);
        chk("reset_ebg_oe", int'(ebg_oe[0]), 0);
        chk("reset_br_n", int'(br_n[0]), 1);
        chk("reset_ebg_n", int'(ebg_n[0]), 31);
        chk("reset_state", int'(st[0]), 0);
        reset_n_in = 1'b1;
        tick();
        chk("oe_after_release", int'(own_oe[0]), 1);

        // Basic grant/own/release cycle for slot 2.
        strobes(2);
        seq.delete();
        ebr_n_in = 5'b11011;
        run_until(0, 2'd1, "s1_req");
        chk("s1_br_low", int'(br_n[0]), 0);
        strobes(3);
        bg_n_in = 1'b0;
        run_until(0, 2'd2, "s1_grant");
        chk("s1_ebg", int'(ebg_n[0]), 27);
        chk("s1_slot", int'(slot[0]), 2);
        strobes(2);
        ebgack_n_in = 1'b0;
        run_until(0, 2'd3, "s1_owned");
        chk("s1_own_low", int'(own_n[0]), 0);
        strobes(5);
        ebgack_n_in = 1'b1;
        ebr_n_in = '1;
        run_until(0, 2'd0, "s1_release");
        bg_n_in = 1'b1;
        chk("s1_seq_len", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++) chk("s1_seq", seq[i], (i + 1) % 4);
        chk("s1_rr_model", m_rr[0], 3);

        // Slots 0 and 4 requesting continuously from rr = 0.
        do_reset();
        ebr_n_in = 5'b01110; bg_n_in = 1'b0; auto_ack = 1'b1;
        grants0.delete(); grants1.delete();
        for (int b = 0; b < 800 && grants0.size() < 4; b++) tick();
        chk("s2_rr_count", grants0.size(), 4);
        for (int i = 0; i < grants0.size() && i < 4; i++) chk("s2_rr_slot", grants0[i], exp_rr[i]);
        for (int i = 0; i < grants1.size() && i < 4; i++) chk("s2_fixed_slot", grants1[i], 0);
        ebr_n_in = '1;
        run_until(0, 2'd0, "s2_idle_rr");
        run_until(1, 2'd0, "s2_idle_fx");
        auto_ack = 1'b0; ebgack_n_in = 1'b1;

        // Grant timeout and lockout of slot 1.
        do_reset();
        ebr_n_in = 5'b11101; bg_n_in = 1'b0;
        run_until(0, 2'd2, "s3_grant");
        g_strobes = 0; pulse_cnt = 0;
        run_until(0, 2'd0, "s3_timeout");
        strobes(1);
        chk("s3_strobes_to_timeout", g_strobes, 16);
        chk("s3_pulse_width", pulse_cnt, 1);
        chk("s3_ebg_released", int'(ebg_n[0]), 31);
        seq.delete();
        strobes(6);
        chk("s3_lockout_hold", seq.size(), 0);
        ebr_n_in = '1;
        strobes(2);
        ebr_n_in = 5'b11101;
        run_until(0, 2'd2, "s3_regrant");
        chk("s3_regrant_slot", int'(slot[0]), 1);
        ebr_n_in = '1;
        run_until(0, 2'd0, "s3_withdraw_granted");
        chk("s3_br_released", int'(br_n[0]), 1);
        chk("s3_rr_model", m_rr[0], 2);

        // access_state_idle gating of the grant.
        ebr_n_in = 5'b10111; access_state_idle = 1'b0;
        run_until(0, 2'd1, "s4_req");
        strobes(6);
        chk("s4_held_req", int'(st[0]), 1);
        chk("s4_no_ebg", int'(ebg_n[0]), 31);
        while (cyc_n % 4 != 3) tick();
        access_state_idle = 1'b1;
        tick();
        chk("s4_first_strobe_grant", int'(st[0]), 2);
        chk("s4_slot", int'(slot[0]), 3);
        ebr_n_in = '1;
        run_until(0, 2'd0, "s4_withdraw");
        chk("s4_ebg_released", int'(ebg_n[0]), 31);
        chk("s4_rr_model", m_rr[0], 2);

        // Withdraw in REQ_CPU, then rr = 2 must pick slot 3 over slot 1.
        bg_n_in = 1'b1; ebr_n_in = 5'b10101;
        run_until(0, 2'd1, "s5_req");
        strobes(2);
        ebr_n_in = '1;
        run_until(0, 2'd0, "s5_withdraw_req");
        chk("s5_br_released", int'(br_n[0]), 1);
        chk("s5_rr_model", m_rr[0], 2);
        bg_n_in = 1'b0; ebr_n_in = 5'b10101;
        run_until(0, 2'd2, "s5_grant");
        chk("s5_rr_slot", int'(slot[0]), 3);
        chk("s5_fixed_slot", int'(slot[1]), 1);
        ebr_n_in = '1;
        run_until(0, 2'd0, "s5_idle_rr");
        run_until(1, 2'd0, "s5_idle_fx");

        // Reset while a slot owns the bus.
        do_reset();
        auto_ack = 1'b1; ebr_n_in = 5'b11110; bg_n_in = 1'b0;
        run_until(0, 2'd3, "s6_owned");
        reset_n_in = 1'b0;
        #1;
        chk("s6_br_oe", int'(br_oe[0]), 0);
        chk("s6_ebg_oe", int'(ebg_oe[0]), 0);
        chk("s6_own_oe", int'(own_oe[0]), 0);
        chk("s6_ebg_n", int'(ebg_n[0]), 31);
        chk("s6_own_n", int'(own_n[0]), 1);
        chk("s6_state", int'(st[0]), 0);
        model_reset();
        auto_ack = 1'b0; ebgack_n_in = 1'b1; ebr_n_in = '1; bg_n_in = 1'b1;
        tick();
        tick();
        reset_n_in = 1'b1;
        tick();
        chk("s6_oe_back", int'(br_oe[0]), 1);
        chk("s6_idle", int'(st[0]), 0);
        chk("s6_br_inactive", int'(br_n[0]), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) ebr_n_in = ebr_n_in ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 19) == 0) bg_n_in = ~bg_n_in;
            if ($urandom_range(0, 9) == 0) ebgack_n_in = ~ebgack_n_in;
            if ($urandom_range(0, 7) == 0) access_state_idle = ~access_state_idle;
            reset_n_in = (i != 2000);
            cpuclk_rising = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/zorro_bus_arbiter.md
Name: zorro_bus_arbiter

Overview:
- Parametrised Zorro expansion-bus arbiter; successor to the fixed 5-slot arbitration inside the rebuster core.
- Collects N_SLOTS slot requests (EBR_n) and obtains the CPU bus via BR/BG.
- Issues one EBG_n grant at a time, round-robin or fixed priority, and tracks ownership through EBGACK_n.
- Adds grant timeout, per-slot lockout and grant-slot reporting, none of which the previous arbiter had.

Parameters:
- N_SLOTS, 5: number of expansion request/grant pairs (2..8).
- SLOT_W, 3: width of grant_slot; must satisfy 2^SLOT_W >= N_SLOTS.
- GRANT_TIMEOUT, 16: cpuclk ticks allowed between EBG_n assert and EBGACK_n assert (1..255).
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed, lowest index wins.

Ports:
- clk100  in  1  system clock, 100 MHz.
- reset_n_in  in  1  reset, asynchronous, active-low.
- cpuclk_rising  in  1  one-clk100 strobe; the FSM and timeout counter advance only on strobe cycles.
- access_state_idle  in  1  CPU-side access engine idle; a grant may issue only while high.
- ebr_n_in  in  N_SLOTS  slot bus requests, active-low, asynchronous.
- ebgack_n_in  in  1  bus-grant acknowledge, active-low, asynchronous.
- bg_n_in  in  1  CPU bus grant, active-low, asynchronous.
- br_n_out / br_n_oe  out  1/1  CPU bus request and its output enable.
- ebg_n_out / ebg_n_oe  out  N_SLOTS/N_SLOTS  slot grants and their output enables.
- own_n_out / own_n_oe  out  1/1  expansion-owns-bus indication and its output enable.
- bm_state  out  2  0 IDLE, 1 REQ_CPU, 2 GRANTED, 3 OWNED.
- grant_slot  out  SLOT_W  index of the slot currently granted or owning; 0 in IDLE.
- timeout_pulse  out  1  one clk100 pulse when a grant times out.

Behaviour:
- Reset asserted (asynchronous):
  - all *_oe = 0; br_n_out = 1; ebg_n_out all 1; own_n_out = 1.
  - bm_state = 0, grant_slot = 0, timeout_pulse = 0.
  - rr pointer = 0; lockout mask = 0; timeout counter = 0.
- After reset release, all oe = 1 from the first clk100 edge.
- Reset mid-operation releases every output immediately, with no handoff.
- Synchronisation: ebr_n_in, ebgack_n_in and bg_n_in each pass a 2-flop synchroniser. FSM decisions use only synchronised values on strobe cycles.
- eligible = ~ebr_sync & ~lockout.
- IDLE:
  - On a strobe with any eligible bit set: br_n_out = 0, go to REQ_CPU.
  - Winner is latched at this transition. PRIORITY_MODE 0: first eligible index at or after rr, wrapping modulo N_SLOTS. PRIORITY_MODE 1: lowest eligible index.
- REQ_CPU:
  - Winner's request withdrawn: br_n_out = 1, go to IDLE.
  - Else if bg_sync low and access_state_idle high: ebg_n_out[winner] = 0, grant_slot = winner, counter cleared, go to GRANTED.
- GRANTED:
  - Counter increments on each strobe.
  - ebgack_sync low: own_n_out = 0, go to OWNED.
  - Winner's request withdrawn: drop EBG and BR, go to IDLE; rr is not advanced.
  - Counter reaches GRANT_TIMEOUT with no ack: drop EBG and BR, set lockout[winner], pulse timeout_pulse, set rr = winner+1 mod N_SLOTS, go to IDLE.
  - If ack and timeout occur on the same strobe, the ack wins.
- OWNED:
  - EBG_n held low while EBGACK_n low; BR held low.
  - On a strobe with ebgack_sync high: drop EBG, BR and OWN; set rr = winner+1 mod N_SLOTS; go to IDLE.
  - New requests are ignored until IDLE; they are never pre-empted.
- Lockout: lockout[k] clears on any strobe where ebr_sync[k] is high.
- Exactly one ebg_n_out bit is low at any time, or none.
- Minimum latency from a request edge to BR low: 2 clk100 synchroniser cycles, then the next strobe.

Test Plan:
- Slot 2 requests; bg_n_in low after 3 strobes; ack after 2 strobes; release after 5 strobes -> br_n_out low, ebg_n_out = 5'b11011, own_n_out low while acked, grant_slot = 2, bm_state sequence 1,2,3,0; rr = 3 afterwards.
- Round-robin with slots 0 and 4 requesting continuously, rr = 0 -> grants alternate 0,4,0,4; fixed mode (PRIORITY_MODE 1) with the same stimulus -> always 0.
- Slot 1 granted, no ack for 16 strobes -> timeout_pulse exactly one clk100 wide, EBG released, slot 1 ignored while EBR_n stays low, regranted after it deasserts then reasserts.
- access_state_idle held low while bg_n_in is low -> remains in REQ_CPU with no EBG; EBG asserts on the first strobe after idle goes high.
- Request withdrawn in REQ_CPU and in GRANTED -> BR and EBG released, return to IDLE, rr unchanged.
- Reset asserted during OWNED -> all oe drop to 0 in the same cycle; after release, state IDLE with outputs inactive-high.
